// File: rtl/path_stack.sv
// path_stack: LIFO store of 2-bit maze moves.
// Exploration pushes moves. Backtracking pops them and gets back the reversed
// direction. After the goal is reached, replay walks the stack from the bottom
// to the top, so the moves come out in forward order.
module path_stack #(
    parameter int unsigned DEPTH = 256,
    parameter int unsigned PW    = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [1:0]    dirIn,
    input  logic          rdStart,
    input  logic          rdNext,
    output logic [1:0]    dirOut,
    output logic          outValid,
    output logic          empty,
    output logic          full,
    output logic [PW:0]   depth,
    output logic          rdDone,
    output logic          err
);

    typedef enum logic {
        ST_TRACK  = 1'b0,
        ST_REPLAY = 1'b1
    } state_e;

    logic [1:0]  mem [DEPTH];

    state_e      state_q,     state_d;
    logic [PW:0] sp_q,        sp_d;
    logic [PW:0] rd_ptr_q,    rd_ptr_d;
    logic [1:0]  dir_out_q,   dir_out_d;
    logic        out_valid_q, out_valid_d;
    logic        rd_done_q,   rd_done_d;
    logic        err_q,       err_d;

    logic          mem_we;
    logic [PW-1:0] mem_waddr;
    logic [1:0]    mem_wdata;

    logic          is_empty;
    logic          is_full;
    logic [PW-1:0] sp_idx;
    logic [PW-1:0] top_idx;
    logic [1:0]    top_dir;
    logic [1:0]    rd_dir;

    // Occupancy flags and read taps for the top entry and the replay pointer
    always_comb begin
        is_empty = (sp_q == '0);
        is_full  = (sp_q == (PW+1)'(DEPTH));
        sp_idx   = sp_q[PW-1:0];
        top_idx  = PW'(sp_q - 1'b1);
        top_dir  = mem[top_idx];
        rd_dir   = mem[rd_ptr_q[PW-1:0]];
    end

    // Next-state logic. In tracking mode rdStart wins over push and pop.
    // In replay mode only rdNext does anything.
    always_comb begin
        state_d     = state_q;
        sp_d        = sp_q;
        rd_ptr_d    = rd_ptr_q;
        dir_out_d   = dir_out_q;
        out_valid_d = 1'b0;
        rd_done_d   = rd_done_q;
        err_d       = err_q;
        mem_we      = 1'b0;
        mem_waddr   = sp_idx;
        mem_wdata   = dirIn;

        unique case (state_q)
            ST_TRACK: begin
                if (rdStart) begin
                    rd_ptr_d  = '0;
                    rd_done_d = is_empty;
                    state_d   = ST_REPLAY;
                end else if (push && pop && !is_empty) begin
                    // Swap the top entry: return the old top reversed and
                    // store the new move in its place. Depth does not change.
                    mem_we      = 1'b1;
                    mem_waddr   = top_idx;
                    dir_out_d   = top_dir + 2'd2;
                    out_valid_d = 1'b1;
                end else if (push) begin
                    if (is_full) begin
                        err_d = 1'b1;
                    end else begin
                        mem_we = 1'b1;
                        sp_d   = sp_q + 1'b1;
                    end
                end else if (pop) begin
                    if (is_empty) begin
                        err_d = 1'b1;
                    end else begin
                        sp_d        = sp_q - 1'b1;
                        dir_out_d   = top_dir + 2'd2;
                        out_valid_d = 1'b1;
                    end
                end
            end
            ST_REPLAY: begin
                if (rdNext && (rd_ptr_q < sp_q)) begin
                    dir_out_d   = rd_dir;
                    out_valid_d = 1'b1;
                    rd_ptr_d    = rd_ptr_q + 1'b1;
                    if ((rd_ptr_q + 1'b1) == sp_q) begin
                        rd_done_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_TRACK;
        endcase
    end

    // Control and output registers. Synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_TRACK;
            sp_q        <= '0;
            rd_ptr_q    <= '0;
            dir_out_q   <= '0;
            out_valid_q <= 1'b0;
            rd_done_q   <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            sp_q        <= sp_d;
            rd_ptr_q    <= rd_ptr_d;
            dir_out_q   <= dir_out_d;
            out_valid_q <= out_valid_d;
            rd_done_q   <= rd_done_d;
            err_q       <= err_d;
        end
    end

    // Move storage. The contents are not reset, and no write happens while
    // reset is asserted.
    always_ff @(posedge clk) begin
        if (rst && mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    assign dirOut   = dir_out_q;
    assign outValid = out_valid_q;
    assign rdDone   = rd_done_q;
    assign err      = err_q;
    assign empty    = is_empty;
    assign full     = is_full;
    assign depth    = sp_q;

endmodule

// File: tb/tb_path_stack.sv
// Directed bench for path_stack. It covers push/pop reversal, underflow and
// overflow errors, top-of-stack swap, replay order and reset during replay.
module tb_path_stack;

    localparam int unsigned DEPTH = 256;
    localparam int unsigned PW    = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          push;
    logic          pop;
    logic [1:0]    dirIn;
    logic          rdStart;
    logic          rdNext;
    logic [1:0]    dirOut;
    logic          outValid;
    logic          empty;
    logic          full;
    logic [PW:0]   depth;
    logic          rdDone;
    logic          err;

    int unsigned total = 0;
    int unsigned bad   = 0;

    path_stack #(.DEPTH(DEPTH), .PW(PW)) dut (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .pop      (pop),
        .dirIn    (dirIn),
        .rdStart  (rdStart),
        .rdNext   (rdNext),
        .dirOut   (dirOut),
        .outValid (outValid),
        .empty    (empty),
        .full     (full),
        .depth    (depth),
        .rdDone   (rdDone),
        .err      (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Apply one set of inputs for exactly one rising edge and sample 1 time unit later.
    task automatic cyc(input logic r, input logic pu, input logic po, input logic [1:0] d,
                       input logic rs, input logic rn);
        rst = r; push = pu; pop = po; dirIn = d; rdStart = rs; rdNext = rn;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        cyc(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
    endtask
    task automatic do_push(input logic [1:0] d);
        cyc(1'b1, 1'b1, 1'b0, d, 1'b0, 1'b0);
    endtask
    task automatic do_pop();
        cyc(1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0);
    endtask
    task automatic do_idle();
        cyc(1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_dirOut"},   32'(dirOut),   32'd0);
        chk({tag, "_outValid"}, 32'(outValid), 32'd0);
        chk({tag, "_rdDone"},   32'(rdDone),   32'd0);
        chk({tag, "_err"},      32'(err),      32'd0);
        chk({tag, "_empty"},    32'(empty),    32'd1);
        chk({tag, "_full"},     32'(full),     32'd0);
        chk({tag, "_depth"},    32'(depth),    32'd0);
    endtask

    initial begin
        rst = 1'b0; push = 1'b0; pop = 1'b0; dirIn = 2'd0; rdStart = 1'b0; rdNext = 1'b0;

        // 1: reset, then push 0..3 and pop four times -> 1,0,3,2
        do_reset();
        do_reset();
        chk_reset_state("rst");
        do_push(2'd0); do_push(2'd1); do_push(2'd2); do_push(2'd3);
        chk("lifo_depth4", 32'(depth), 32'd4);
        chk("lifo_notempty", 32'(empty), 32'd0);
        do_pop(); chk("pop1_ov", 32'(outValid), 32'd1); chk("pop1_dir", 32'(dirOut), 32'd1);
        do_pop(); chk("pop2_ov", 32'(outValid), 32'd1); chk("pop2_dir", 32'(dirOut), 32'd0);
        do_pop(); chk("pop3_ov", 32'(outValid), 32'd1); chk("pop3_dir", 32'(dirOut), 32'd3);
        do_pop(); chk("pop4_ov", 32'(outValid), 32'd1); chk("pop4_dir", 32'(dirOut), 32'd2);
        do_idle();
        chk("after_pops_ov",    32'(outValid), 32'd0);
        chk("after_pops_hold",  32'(dirOut),   32'd2);
        chk("after_pops_empty", 32'(empty),    32'd1);
        chk("after_pops_depth", 32'(depth),    32'd0);
        chk("after_pops_err",   32'(err),      32'd0);

        // 2: pop on empty sets a sticky err
        do_reset();
        do_pop();
        chk("upop_ov",    32'(outValid), 32'd0);
        chk("upop_err",   32'(err),      32'd1);
        chk("upop_depth", 32'(depth),    32'd0);
        do_push(2'd2);
        chk("upop_push_depth", 32'(depth), 32'd1);
        chk("upop_err_sticky", 32'(err),   32'd1);

        // 3: fill to DEPTH, then overflow; the top entry must survive
        do_reset();
        for (int i = 0; i < int'(DEPTH); i++) begin
            do_push(2'(i));
        end
        chk("fill_full",  32'(full),  32'd1);
        chk("fill_depth", 32'(depth), 32'(DEPTH));
        chk("fill_err",   32'(err),   32'd0);
        do_push(2'd0);
        chk("ovf_full",  32'(full),  32'd1);
        chk("ovf_depth", 32'(depth), 32'(DEPTH));
        chk("ovf_err",   32'(err),   32'd1);
        do_pop();
        chk("ovf_pop_ov",    32'(outValid), 32'd1);
        chk("ovf_pop_dir",   32'(dirOut),   32'd1);
        chk("ovf_pop_depth", 32'(depth),    32'(DEPTH - 1));
        chk("ovf_pop_full",  32'(full),     32'd0);
        do_pop();
        chk("ovf_pop2_dir", 32'(dirOut), 32'd0);

        // 4: push and pop together swap the top entry
        do_reset();
        do_push(2'd1); do_push(2'd3);
        cyc(1'b1, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0);
        chk("swap_ov",    32'(outValid), 32'd1);
        chk("swap_dir",   32'(dirOut),   32'd1);
        chk("swap_depth", 32'(depth),    32'd2);
        do_pop();
        chk("swap_pop_dir",   32'(dirOut), 32'd2);
        chk("swap_pop_depth", 32'(depth),  32'd1);
        do_pop();
        chk("swap_pop2_dir", 32'(dirOut), 32'd3);
        chk("swap_err",      32'(err),    32'd0);
        // push and pop together on an empty stack act as a plain push
        cyc(1'b1, 1'b1, 1'b1, 2'd2, 1'b0, 1'b0);
        chk("pp_empty_ov",    32'(outValid), 32'd0);
        chk("pp_empty_depth", 32'(depth),    32'd1);
        chk("pp_empty_err",   32'(err),      32'd0);
        do_pop();
        chk("pp_empty_pop_dir", 32'(dirOut), 32'd0);

        // 5: replay in forward order; rdStart beats a simultaneous pop
        do_reset();
        do_push(2'd3); do_push(2'd0); do_push(2'd1);
        cyc(1'b1, 1'b0, 1'b1, 2'd0, 1'b1, 1'b0);
        chk("rs_depth",  32'(depth),    32'd3);
        chk("rs_ov",     32'(outValid), 32'd0);
        chk("rs_rdDone", 32'(rdDone),   32'd0);
        cyc(1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1);
        chk("rn1_ov", 32'(outValid), 32'd1); chk("rn1_dir", 32'(dirOut), 32'd3);
        chk("rn1_done", 32'(rdDone), 32'd0);
        cyc(1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 1'b1);
        chk("rn2_ov", 32'(outValid), 32'd1); chk("rn2_dir", 32'(dirOut), 32'd0);
        chk("rn2_depth", 32'(depth), 32'd3);
        cyc(1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1);
        chk("rn3_ov", 32'(outValid), 32'd1); chk("rn3_dir", 32'(dirOut), 32'd1);
        chk("rn3_done", 32'(rdDone), 32'd1);
        cyc(1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1);
        chk("rn4_ov", 32'(outValid), 32'd0); chk("rn4_hold", 32'(dirOut), 32'd1);
        chk("rn4_done", 32'(rdDone), 32'd1);
        do_pop();
        chk("rp_pop_depth", 32'(depth),    32'd3);
        chk("rp_pop_ov",    32'(outValid), 32'd0);
        chk("rp_pop_err",   32'(err),      32'd0);
        do_push(2'd2);
        chk("rp_push_depth", 32'(depth), 32'd3);

        // 6: reset in the middle of replay returns to tracking mode
        do_reset();
        do_push(2'd3); do_push(2'd0); do_push(2'd1);
        cyc(1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1);
        chk("mr_ov",  32'(outValid), 32'd1);
        chk("mr_dir", 32'(dirOut),   32'd3);
        cyc(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1);
        chk_reset_state("mr_rst");
        do_push(2'd1);
        chk("mr_push_depth", 32'(depth), 32'd1);
        do_pop();
        chk("mr_pop_ov",  32'(outValid), 32'd1);
        chk("mr_pop_dir", 32'(dirOut),   32'd3);

        // 7: replay of an empty stack is done at once
        do_reset();
        cyc(1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0);
        chk("er_done", 32'(rdDone), 32'd1);
        cyc(1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1);
        chk("er_ov", 32'(outValid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
